game_round_sequencer: RTL and testbench
=======================================

// Module: game_round_sequencer
// PURPOSE
//  Round/phase controller for the GameLogic pixel datapath. Sequences IDLE->COUNTDOWN->PLAY->RESULT->GAMEOVER
//  on frame boundaries, keeps per-player scores, and double-buffers pose boxes from the predictor so the
//  renderer sees boxes that change only at frame end. Sits between pose predictor, VGA timing and GameLogic.
// PARAMETERS
//  COORD_W          11    bit width of box coordinates
//  N_PLAYER         2     number of players (index 0..N_PLAYER-1)
//  COUNTDOWN_FRAMES 180   frames spent in COUNTDOWN (>=1)
//  ROUND_FRAMES     1800  frames spent in PLAY per round (>=1)
//  RESULT_FRAMES    120   frames spent in RESULT per round (>=1)
//  N_ROUNDS         3     rounds per game (1..4)
// PORTS
//  i_clk           in   1                   system clock
//  i_rst_n         in   1                   synchronous reset, active low
//  i_start         in   1                   1-cycle start pulse
//  i_enter_game    in   1                   level; low forces IDLE
//  i_frame_end     in   1                   1-cycle pulse at end of active video
//  i_predict_valid in   1                   1-cycle pulse, boxes below valid
//  i_left/i_right/i_up/i_down in COORD_W x N_PLAYER  raw predictor boxes
//  i_hit           in   N_PLAYER            per-player 1-cycle score pulse from GameLogic
//  o_left/o_right/o_up/o_down out COORD_W x N_PLAYER committed boxes
//  o_boxes_valid   out  1                   at least one box committed since IDLE
//  o_state         out  3                   0 IDLE,1 COUNTDOWN,2 PLAY,3 RESULT,4 GAMEOVER
//  o_round         out  2                   current round, 0-based
//  o_frames_left   out  12                  frames remaining in current timed state
//  o_score         out  4 x N_PLAYER        per-player score
//  o_winner        out  2                   00 none/tie, 01 player0, 10 player1; valid in GAMEOVER
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): all outputs 0, state IDLE, shadows cleared; takes priority over everything.
//  Box buffering: on i_predict_valid, per player, latch into shadow and set fresh[p] only if left<=right and
//   up<=down; invalid box ignored for that player. On i_frame_end, each fresh[p] shadow copied to o_* and
//   fresh[p] cleared, o_boxes_valid set. Same-cycle predict_valid+frame_end: commit uses pre-update shadow;
//   new box lands in shadow, committed at next frame_end. Output latency: box visible 1 cycle after the frame_end.
//  Buffering runs in every state except IDLE; entering IDLE clears o_boxes_valid (o_* boxes hold value).
//  FSM (all transitions registered, 1-cycle latency):
//   IDLE: i_start & i_enter_game -> COUNTDOWN, frames_left=COUNTDOWN_FRAMES, round=0, scores=0.
//   COUNTDOWN/PLAY/RESULT: each i_frame_end decrements frames_left; frame_end with frames_left==1 exits:
//    COUNTDOWN->PLAY (ROUND_FRAMES); PLAY->RESULT (RESULT_FRAMES);
//    RESULT->COUNTDOWN with round+1 if round<N_ROUNDS-1, else GAMEOVER (frames_left=0).
//    Each timed state thus spans exactly N frame_end pulses.
//   GAMEOVER: hold; i_start -> IDLE.
//   i_enter_game=0 in any state -> IDLE next cycle, scores/round/frames_left cleared; overrides i_start.
//  Scoring: only in PLAY, i_hit[p] increments o_score[p], saturating at 15; simultaneous hits all counted;
//   hit on the cycle of the final PLAY frame_end still counts; hits in other states ignored.
//  o_winner computed on RESULT->GAMEOVER transition: strictly higher score wins, equal -> 00; cleared in IDLE.
//  i_start outside IDLE/GAMEOVER ignored. i_frame_end in IDLE/GAMEOVER does not touch frames_left.
// STRUCTURE
//  game_pkg: typedef enum logic [2:0] game_state_t {ST_IDLE..ST_GAMEOVER}; COORD_W, N_PLAYER constants;
//   typedef struct bbox_t {left,right,up,down}.
//  Sub-module bbox_shadow_reg: one player's validity check + shadow/active double buffer + fresh flag;
//   instantiated N_PLAYER times. FSM, frame counter, scoring and winner logic live in the top.
// TESTING (params COUNTDOWN_FRAMES=3, ROUND_FRAMES=5, RESULT_FRAMES=2, N_ROUNDS=2)
//  1 Reset mid-PLAY with i_rst_n=0 one cycle -> next cycle state=0, scores 0, frames_left 0, boxes_valid 0.
//  2 start with enter_game=1 -> state=1, frames_left=3; 3 frame_ends -> state=2, frames_left=5; 5 more -> state=3.
//  3 Full game: 2 rounds, hit[0] x3, hit[1] x1 in PLAY -> state=4, score={1,3}, o_winner=01; then start -> IDLE.
//  4 predict_valid box0 {100,200,50,150} then frame_end -> o_left[0]=100 one cycle after frame_end;
//    box {300,200,..} (left>right) -> o_left[0] stays 100.
//  5 predict_valid and frame_end same cycle with new box B, shadow holding A -> A committed now, B next frame_end.
//  6 enter_game drops in COUNTDOWN round 1 -> IDLE next cycle; hit[0]&hit[1] together in PLAY -> both +1;
//    17 hits -> score saturates at 15.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game round sequencer.
//   game_state_t : round/phase encoding driven onto o_state
//   bbox_t       : one player's pose bounding box
//   box_ok()     : a box is usable only if left<=right and up<=down
package game_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned N_PLAYER = 2;
    localparam int unsigned SCORE_W  = 4;
    localparam int unsigned FRAMES_W = 12;
    localparam int unsigned ROUND_W  = 2;
    localparam int unsigned WIN_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_RESULT    = 3'd3,
        ST_GAMEOVER  = 3'd4
    } game_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] up;
        logic [COORD_W-1:0] down;
    } bbox_t;

    function automatic logic box_ok(input bbox_t b);
        return (b.left <= b.right) && (b.up <= b.down);
    endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// Bus between the sequencer and its neighbours (predictor, VGA timing, GameLogic).
//   i_* : control pulses, raw predictor boxes, per-player hit pulses
//   o_* : committed boxes, game state, round, frame count, scores, winner
// master drives i_* and observes o_*; slave is the sequencer.
interface game_round_sequencer_if;
    import game_pkg::*;

    logic                                i_start;
    logic                                i_enter_game;
    logic                                i_frame_end;
    logic                                i_predict_valid;
    logic [N_PLAYER-1:0][COORD_W-1:0]    i_left;
    logic [N_PLAYER-1:0][COORD_W-1:0]    i_right;
    logic [N_PLAYER-1:0][COORD_W-1:0]    i_up;
    logic [N_PLAYER-1:0][COORD_W-1:0]    i_down;
    logic [N_PLAYER-1:0]                 i_hit;

    logic [N_PLAYER-1:0][COORD_W-1:0]    o_left;
    logic [N_PLAYER-1:0][COORD_W-1:0]    o_right;
    logic [N_PLAYER-1:0][COORD_W-1:0]    o_up;
    logic [N_PLAYER-1:0][COORD_W-1:0]    o_down;
    logic                                o_boxes_valid;
    logic [2:0]                          o_state;
    logic [ROUND_W-1:0]                  o_round;
    logic [FRAMES_W-1:0]                 o_frames_left;
    logic [N_PLAYER-1:0][SCORE_W-1:0]    o_score;
    logic [WIN_W-1:0]                    o_winner;

    modport master (
        output i_start, i_enter_game, i_frame_end, i_predict_valid,
               i_left, i_right, i_up, i_down, i_hit,
        input  o_left, o_right, o_up, o_down, o_boxes_valid,
               o_state, o_round, o_frames_left, o_score, o_winner
    );

    modport slave (
        input  i_start, i_enter_game, i_frame_end, i_predict_valid,
               i_left, i_right, i_up, i_down, i_hit,
        output o_left, o_right, o_up, o_down, o_boxes_valid,
               o_state, o_round, o_frames_left, o_score, o_winner
    );

endinterface

// File: rtl/game_round_sequencer_bbox_shadow_reg.sv
// One player's box double buffer: validity check, shadow register, active
// register and fresh flag.
//   i_en            : buffering enabled (game not in IDLE); low clears fresh
//   i_predict_valid : latch i_box into shadow if it is a valid box
//   i_frame_end     : copy a fresh shadow into the active box
//   o_box           : committed (active) box
//   o_commit_c      : this frame_end commits a box (combinational)
module bbox_shadow_reg
    import game_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_en,
    input  logic  i_predict_valid,
    input  logic  i_frame_end,
    input  bbox_t i_box,
    output bbox_t o_box,
    output logic  o_commit_c
);

    bbox_t r_shadow;
    bbox_t r_active;
    logic  r_fresh;
    logic  w_accept;

    assign w_accept   = i_predict_valid && box_ok(i_box);
    assign o_commit_c = i_en && i_frame_end && r_fresh;
    assign o_box      = r_active;

    // Commit reads the pre-update shadow, so a box arriving on the frame_end
    // cycle waits in the shadow for the next frame_end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_fresh  <= 1'b0;
        end else if (!i_en) begin
            r_fresh  <= 1'b0;
        end else begin
            if (i_frame_end && r_fresh) begin
                r_active <= r_shadow;
            end
            if (w_accept) begin
                r_shadow <= i_box;
                r_fresh  <= 1'b1;
            end else if (i_frame_end) begin
                r_fresh  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/game_round_sequencer.sv
// Round/phase controller: IDLE->COUNTDOWN->PLAY->RESULT->GAMEOVER on frame
// boundaries, per-player scoring, winner decision, and per-player box double
// buffering so the renderer only sees box changes at frame end.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   io_bus         : control, predictor boxes, hits in; committed boxes and
//                    game status out (see game_round_sequencer_if)
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned ROUND_FRAMES     = 1800,
    parameter int unsigned RESULT_FRAMES    = 120,
    parameter int unsigned N_ROUNDS         = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    game_round_sequencer_if.slave   io_bus
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_t                      r_state;
    logic [ROUND_W-1:0]               r_round;
    logic [FRAMES_W-1:0]              r_frames_left;
    logic [N_PLAYER-1:0][SCORE_W-1:0] r_score;
    logic [WIN_W-1:0]                 r_winner;
    logic                             r_boxes_valid;

    logic                             w_active;
    logic [N_PLAYER-1:0]              w_commit_c;
    logic                             w_last_frame;
    logic [WIN_W-1:0]                 w_winner;
    bbox_t                            w_box [N_PLAYER];
    logic [N_PLAYER-1:0][COORD_W-1:0] w_left, w_right, w_up, w_down;

    assign w_active     = (r_state != ST_IDLE);
    assign w_last_frame = io_bus.i_frame_end && (r_frames_left == FRAMES_W'(1));

    // Two-player winner: strictly higher score wins, tie reports none.
    always_comb begin
        w_winner = 2'b00;
        if (r_score[0] > r_score[1]) begin
            w_winner = 2'b01;
        end else if (r_score[1] > r_score[0]) begin
            w_winner = 2'b10;
        end
    end

    for (genvar p = 0; p < N_PLAYER; p++) begin : g_player
        bbox_t w_in;
        assign w_in = '{left:  io_bus.i_left[p],
                        right: io_bus.i_right[p],
                        up:    io_bus.i_up[p],
                        down:  io_bus.i_down[p]};

        bbox_shadow_reg u_shadow (
            .i_clk           (i_clk),
            .i_rst_n         (i_rst_n),
            .i_en            (w_active),
            .i_predict_valid (io_bus.i_predict_valid),
            .i_frame_end     (io_bus.i_frame_end),
            .i_box           (w_in),
            .o_box           (w_box[p]),
            .o_commit_c      (w_commit_c[p])
        );
    end

    // Repack per-player boxes into the bus arrays.
    always_comb begin
        w_left  = '0;
        w_right = '0;
        w_up    = '0;
        w_down  = '0;
        for (int p = 0; p < N_PLAYER; p++) begin
            w_left[p]  = w_box[p].left;
            w_right[p] = w_box[p].right;
            w_up[p]    = w_box[p].up;
            w_down[p]  = w_box[p].down;
        end
    end

    // Phase FSM with frame counter, scoring and winner.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_round       <= '0;
            r_frames_left <= '0;
            r_score       <= '0;
            r_winner      <= '0;
            r_boxes_valid <= 1'b0;
        end else if (!io_bus.i_enter_game) begin
            r_state       <= ST_IDLE;
            r_round       <= '0;
            r_frames_left <= '0;
            r_score       <= '0;
            r_winner      <= '0;
            r_boxes_valid <= 1'b0;
        end else begin
            if (|w_commit_c) begin
                r_boxes_valid <= 1'b1;
            end
            // Hits count on every PLAY cycle, including the exiting frame_end.
            if (r_state == ST_PLAY) begin
                for (int p = 0; p < N_PLAYER; p++) begin
                    if (io_bus.i_hit[p] && (r_score[p] != SCORE_MAX)) begin
                        r_score[p] <= r_score[p] + SCORE_W'(1);
                    end
                end
            end
            case (r_state)
                ST_IDLE: begin
                    r_winner      <= '0;
                    r_boxes_valid <= 1'b0;
                    if (io_bus.i_start) begin
                        r_state       <= ST_COUNTDOWN;
                        r_frames_left <= FRAMES_W'(COUNTDOWN_FRAMES);
                        r_round       <= '0;
                        r_score       <= '0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (w_last_frame) begin
                        r_state       <= ST_PLAY;
                        r_frames_left <= FRAMES_W'(ROUND_FRAMES);
                    end else if (io_bus.i_frame_end) begin
                        r_frames_left <= r_frames_left - FRAMES_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (w_last_frame) begin
                        r_state       <= ST_RESULT;
                        r_frames_left <= FRAMES_W'(RESULT_FRAMES);
                    end else if (io_bus.i_frame_end) begin
                        r_frames_left <= r_frames_left - FRAMES_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (w_last_frame) begin
                        if (r_round < ROUND_W'(N_ROUNDS - 1)) begin
                            r_state       <= ST_COUNTDOWN;
                            r_round       <= r_round + ROUND_W'(1);
                            r_frames_left <= FRAMES_W'(COUNTDOWN_FRAMES);
                        end else begin
                            r_state       <= ST_GAMEOVER;
                            r_frames_left <= '0;
                            r_winner      <= w_winner;
                        end
                    end else if (io_bus.i_frame_end) begin
                        r_frames_left <= r_frames_left - FRAMES_W'(1);
                    end
                end
                ST_GAMEOVER: begin
                    if (io_bus.i_start) begin
                        r_state       <= ST_IDLE;
                        r_winner      <= '0;
                        r_boxes_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.o_left        = w_left;
    assign io_bus.o_right       = w_right;
    assign io_bus.o_up          = w_up;
    assign io_bus.o_down        = w_down;
    assign io_bus.o_boxes_valid = r_boxes_valid;
    assign io_bus.o_state       = r_state;
    assign io_bus.o_round       = r_round;
    assign io_bus.o_frames_left = r_frames_left;
    assign io_bus.o_score       = r_score;
    assign io_bus.o_winner      = r_winner;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations after each
// clock edge; a monitor pops and compares them on the following falling edge.
module tb_game_round_sequencer;
    import game_pkg::*;

    localparam int F_STATE  = 0;
    localparam int F_ROUND  = 1;
    localparam int F_FRAMES = 2;
    localparam int F_SCORE  = 3;
    localparam int F_WINNER = 4;
    localparam int F_BVALID = 5;
    localparam int F_LEFT   = 6;
    localparam int F_RIGHT  = 7;

    typedef struct {
        string name;
        int    field;
        int    idx;
        int    value;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    game_round_sequencer_if bus ();

    game_round_sequencer #(
        .COUNTDOWN_FRAMES (3),
        .ROUND_FRAMES     (5),
        .RESULT_FRAMES    (2),
        .N_ROUNDS         (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: registered outputs are stable mid-cycle; compare queued items.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                int   act;
                e = q.pop_front();
                case (e.field)
                    F_STATE:  act = int'(bus.o_state);
                    F_ROUND:  act = int'(bus.o_round);
                    F_FRAMES: act = int'(bus.o_frames_left);
                    F_SCORE:  act = int'(bus.o_score[e.idx]);
                    F_WINNER: act = int'(bus.o_winner);
                    F_BVALID: act = int'(bus.o_boxes_valid);
                    F_LEFT:   act = int'(bus.o_left[e.idx]);
                    F_RIGHT:  act = int'(bus.o_right[e.idx]);
                    default:  act = -1;
                endcase
                n_checks++;
                if (act == e.value) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.value);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int field, input int idx, input int value);
        q.push_back('{name: name, field: field, idx: idx, value: value});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_frame_end = 1'b1;
            tick();
            bus.i_frame_end = 1'b0;
        end
    endtask

    task automatic start_pulse();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic hit(input logic [1:0] h);
        bus.i_hit = h;
        tick();
        bus.i_hit = 2'b00;
    endtask

    task automatic set_box(input int p, input int l, input int r, input int u, input int d);
        bus.i_left[p]  = COORD_W'(l);
        bus.i_right[p] = COORD_W'(r);
        bus.i_up[p]    = COORD_W'(u);
        bus.i_down[p]  = COORD_W'(d);
    endtask

    task automatic expect_sf(input string name, input int st, input int fr);
        expect_val({name, "_state"}, F_STATE, 0, st);
        expect_val({name, "_frames"}, F_FRAMES, 0, fr);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_enter_game    = 1'b0;
        bus.i_frame_end     = 1'b0;
        bus.i_predict_valid = 1'b0;
        bus.i_hit           = 2'b00;
        bus.i_left          = '0;
        bus.i_right         = '0;
        bus.i_up            = '0;
        bus.i_down          = '0;
        tick();
        tick();
        expect_sf("rst", 0, 0);
        expect_val("rst_score0", F_SCORE, 0, 0);
        expect_val("rst_bvalid", F_BVALID, 0, 0);
        expect_val("rst_winner", F_WINNER, 0, 0);

        rst_n            = 1'b1;
        bus.i_enter_game = 1'b1;
        tick();

        // Full two-round game
        start_pulse();
        expect_sf("start", 1, 3);
        expect_val("start_round", F_ROUND, 0, 0);
        frames(2);
        expect_sf("cd_dec", 1, 1);
        frames(1);
        expect_sf("cd_exit", 2, 5);
        hit(2'b01);
        expect_val("hit0_a", F_SCORE, 0, 1);
        hit(2'b11);
        expect_val("both_s0", F_SCORE, 0, 2);
        expect_val("both_s1", F_SCORE, 1, 1);
        frames(4);
        expect_sf("play_dec", 2, 1);
        bus.i_hit = 2'b01;
        frames(1);
        bus.i_hit = 2'b00;
        expect_sf("play_exit", 3, 2);
        expect_val("final_frame_hit", F_SCORE, 0, 3);
        hit(2'b10);
        expect_val("result_hit_ignored", F_SCORE, 1, 1);
        start_pulse();
        expect_sf("result_start_ign", 3, 2);
        frames(2);
        expect_sf("r0_to_cd", 1, 3);
        expect_val("round1", F_ROUND, 0, 1);
        frames(3);
        expect_sf("r1_play", 2, 5);
        frames(5);
        expect_sf("r1_result", 3, 2);
        frames(2);
        expect_sf("gameover", 4, 0);
        expect_val("go_score0", F_SCORE, 0, 3);
        expect_val("go_score1", F_SCORE, 1, 1);
        expect_val("go_winner", F_WINNER, 0, 1);
        frames(1);
        expect_sf("go_frame_ign", 4, 0);
        start_pulse();
        expect_sf("go_to_idle", 0, 0);
        expect_val("idle_winner", F_WINNER, 0, 0);

        // Reset in the middle of PLAY with a box committed
        start_pulse();
        frames(3);
        expect_sf("rp_play", 2, 5);
        set_box(0, 10, 20, 30, 40);
        bus.i_predict_valid = 1'b1;
        tick();
        bus.i_predict_valid = 1'b0;
        hit(2'b01);
        frames(1);
        expect_val("rp_bvalid", F_BVALID, 0, 1);
        expect_val("rp_left0", F_LEFT, 0, 10);
        expect_val("rp_score0", F_SCORE, 0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_sf("rp_rst", 0, 0);
        expect_val("rp_rst_score0", F_SCORE, 0, 0);
        expect_val("rp_rst_bvalid", F_BVALID, 0, 0);
        expect_val("rp_rst_left0", F_LEFT, 0, 0);

        // Box buffering
        start_pulse();
        set_box(0, 100, 200, 50, 150);
        set_box(1, 1, 2, 3, 4);
        bus.i_predict_valid = 1'b1;
        tick();
        bus.i_predict_valid = 1'b0;
        expect_val("box_not_yet", F_LEFT, 0, 0);
        expect_val("box_bvalid_0", F_BVALID, 0, 0);
        frames(1);
        expect_val("box_left0", F_LEFT, 0, 100);
        expect_val("box_right0", F_RIGHT, 0, 200);
        expect_val("box_left1", F_LEFT, 1, 1);
        expect_val("box_bvalid_1", F_BVALID, 0, 1);
        set_box(0, 300, 200, 50, 150);
        bus.i_predict_valid = 1'b1;
        tick();
        bus.i_predict_valid = 1'b0;
        frames(1);
        expect_val("box_invalid", F_LEFT, 0, 100);
        expect_sf("box_cd", 1, 1);
        set_box(0, 111, 222, 0, 10);
        bus.i_predict_valid = 1'b1;
        tick();
        set_box(0, 123, 300, 0, 10);
        bus.i_frame_end = 1'b1;
        tick();
        bus.i_frame_end     = 1'b0;
        bus.i_predict_valid = 1'b0;
        expect_val("same_cyc_A", F_LEFT, 0, 111);
        expect_val("same_cyc_p1_hold", F_LEFT, 1, 1);
        expect_sf("same_cyc_play", 2, 5);
        frames(1);
        expect_val("same_cyc_B", F_LEFT, 0, 123);
        expect_val("same_cyc_B_r", F_RIGHT, 0, 300);

        // Saturation, then enter_game drop in round-1 COUNTDOWN
        for (int i = 0; i < 17; i++) hit(2'b10);
        expect_val("sat_s1", F_SCORE, 1, 15);
        expect_val("sat_s0", F_SCORE, 0, 0);
        frames(4);
        expect_sf("sat_result", 3, 2);
        frames(2);
        expect_sf("eg_cd", 1, 3);
        expect_val("eg_round", F_ROUND, 0, 1);
        bus.i_enter_game = 1'b0;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start      = 1'b0;
        expect_sf("eg_idle", 0, 0);
        expect_val("eg_round0", F_ROUND, 0, 0);
        expect_val("eg_score1", F_SCORE, 1, 0);
        expect_val("eg_bvalid", F_BVALID, 0, 0);
        expect_val("eg_left_hold", F_LEFT, 0, 123);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached expected completion");
        $fatal(1, "timeout");
    end

endmodule
